// File: rtl/dispense_pkg.sv
// Shared types and widths for the dose dispense scheduler.
package dispense_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  // Width of a down-counter that can hold the larger of the two durations.
  function automatic int clog2_max(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dispense_arbiter.sv
// Combinational grant picker: one-hot grant over the pending channels.
// DISPENSE_ROUND_ROBIN_EN selects rotating priority; otherwise lowest index wins.
module dispense_arbiter #(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = 2
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [PTR_W-1:0]  last_grant,
  output logic [NUM_CH-1:0] grant,
  output logic              valid
);

  assign valid = |pending;

`ifdef DISPENSE_ROUND_ROBIN_EN
  int               idx_int;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Search begins one past the previous winner and wraps around.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    idx_int = 0;
    idx     = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx_int = (int'(last_grant) + i) % NUM_CH;
      idx     = idx_int[PTR_W-1:0];
      if (!found && pending[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^last_grant;

  // Isolate the lowest set bit.
  assign grant = pending & (~pending + NUM_CH'(1));
`endif

endmodule

// File: rtl/dispense_scheduler.sv
// Multi-slot dose scheduler: queues doses on time matches, pulses one motor at a time.
// Optional DISPENSE_ROUND_ROBIN_EN switches the grant policy to round-robin.
module dispense_scheduler
  import dispense_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int NUM_SLOTS    = 3,
  parameter int PULSE_CYCLES = 50000000,
  parameter int GAP_CYCLES   = 5000000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        sec_pulse,
  input  logic [HOUR_W-1:0]           hours,
  input  logic [MIN_W-1:0]            minutes,
  input  logic [SEC_W-1:0]            seconds,
  input  logic [NUM_SLOTS*HOUR_W-1:0] slot_hour,
  input  logic [NUM_SLOTS*MIN_W-1:0]  slot_min,
  input  logic [NUM_CH*NUM_SLOTS-1:0] ch_mask,
  input  logic [NUM_CH-1:0]           manual_req,
  output logic [NUM_CH-1:0]           motor,
  output logic [NUM_CH-1:0]           pending,
  output logic [NUM_CH-1:0]           overflow,
  output logic                        busy
);

  localparam int TMR_W = clog2_max(PULSE_CYCLES, GAP_CYCLES);
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [NUM_SLOTS-1:0] match;
  logic [NUM_CH-1:0]  req;
  logic [NUM_CH-1:0]  grant;
  logic [NUM_CH-1:0]  grant_clr;
  logic               grant_valid;
  logic [PTR_W-1:0]   last_grant;

  // Out-of-range slot times are rejected so a bad setting can never fire.
  always_comb begin
    match = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      match[s] = sec_pulse && (seconds == '0)
              && (hours == slot_hour[s*HOUR_W +: HOUR_W])
              && (minutes == slot_min[s*MIN_W +: MIN_W])
              && (slot_hour[s*HOUR_W +: HOUR_W] <= HOUR_W'(23))
              && (slot_min[s*MIN_W +: MIN_W] <= MIN_W'(59));
    end
  end

  always_comb begin
    req = manual_req;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (match[s] && ch_mask[c*NUM_SLOTS + s]) req[c] = 1'b1;
      end
    end
  end

  dispense_arbiter #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_arbiter (
    .pending    (pending),
    .last_grant (last_grant),
    .grant      (grant),
    .valid      (grant_valid)
  );

  assign grant_clr = (state == IDLE) ? grant : '0;
  assign busy      = (state != IDLE);

`ifdef DISPENSE_ROUND_ROBIN_EN
  logic [PTR_W-1:0] grant_idx;

  always_comb begin
    grant_idx = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) grant_idx = PTR_W'(c);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_grant <= PTR_W'(NUM_CH - 1);
    end else if (state == IDLE && grant_valid) begin
      last_grant <= grant_idx;
    end
  end
`else
  assign last_grant = PTR_W'(NUM_CH - 1);
`endif

  // A new request wins over a same-edge grant clear so the dose is re-queued.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      timer    <= '0;
      motor    <= '0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      pending  <= (pending & ~grant_clr) | req;
      overflow <= overflow | (req & pending);
      case (state)
        IDLE: begin
          if (grant_valid) begin
            motor <= grant;
            timer <= PULSE_LOAD;
            state <= PULSE;
          end
        end
        PULSE: begin
          if (timer == '0) begin
            motor <= '0;
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              timer <= GAP_LOAD;
              state <= GAP;
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        GAP: begin
          if (timer == '0) state <= IDLE;
          else             timer <= timer - TMR_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dispense_scheduler.sv
// Scoreboard bench for dispense_scheduler: expected grants queued at request time.
module tb_dispense_scheduler;

  localparam int NUM_CH       = 4;
  localparam int NUM_SLOTS    = 3;
  localparam int PULSE_CYCLES = 4;
  localparam int GAP_CYCLES   = 2;

  logic        clock;
  logic        reset;
  logic        sec_pulse;
  logic [4:0]  hours;
  logic [5:0]  minutes;
  logic [5:0]  seconds;
  logic [14:0] slot_hour;
  logic [17:0] slot_min;
  logic [11:0] ch_mask;
  logic [3:0]  manual_req;
  logic [3:0]  motor;
  logic [3:0]  pending;
  logic [3:0]  overflow;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] exp_q[$];
  logic [3:0] prev_m;
  logic [3:0] exp_m;
  int         hi_cnt;
  int         lo_cnt;
  bit         had_pulse;

  dispense_scheduler #(
    .NUM_CH       (NUM_CH),
    .NUM_SLOTS    (NUM_SLOTS),
    .PULSE_CYCLES (PULSE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .sec_pulse  (sec_pulse),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .slot_hour  (slot_hour),
    .slot_min   (slot_min),
    .ch_mask    (ch_mask),
    .manual_req (manual_req),
    .motor      (motor),
    .pending    (pending),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step(1);
      if (busy == 1'b0 && pending == '0 && motor == '0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  // Pulse monitor: grant order, pulse width and inter-pulse spacing.
  always @(negedge clock) begin
    if (!reset) begin
      prev_m    = '0;
      hi_cnt    = 0;
      lo_cnt    = 0;
      had_pulse = 1'b0;
    end else begin
      if (motor != '0 && motor != prev_m) begin
        if (had_pulse) check("gap_len", (lo_cnt >= GAP_CYCLES), 1);
        if (exp_q.size() == 0) begin
          check("unexp_pulse", motor, 0);
        end else begin
          exp_m = exp_q.pop_front();
          check("grant", motor, exp_m);
        end
        hi_cnt = 1;
      end else if (motor != '0) begin
        hi_cnt++;
      end else if (prev_m != '0) begin
        check("pulse_w", hi_cnt, PULSE_CYCLES);
        had_pulse = 1'b1;
        lo_cnt    = 1;
      end else begin
        lo_cnt++;
      end
      prev_m = motor;
    end
  end

  initial begin
    reset      = 1'b0;
    sec_pulse  = 1'b0;
    hours      = 5'd0;
    minutes    = 6'd0;
    seconds    = 6'd0;
    slot_hour  = {5'd24, 5'd8, 5'd8};
    slot_min   = {6'd0, 6'd0, 6'd0};
    ch_mask    = 12'h843;
    manual_req = 4'h0;

    step(3);
    check("rst_motor", motor, 0);
    check("rst_pending", pending, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    step(1);

    // All four channels pending at once, twice.
    for (int r = 0; r < 2; r++) begin
      manual_req = 4'hF;
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000);
      step(1);
      manual_req = 4'h0;
      check("all_pend", pending, 4'hF);
      wait_idle();
    end

    // Slot match at 08:00:00 (two slots overlap on channel 0).
    hours     = 5'd8;
    minutes   = 6'd0;
    seconds   = 6'd0;
    sec_pulse = 1'b1;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0100);
    step(1);
    sec_pulse = 1'b0;
    check("slot_pend", pending, 4'b0101);
    check("slot_ovf", overflow, 0);
    step(1);
    check("slot_busy", busy, 1);
    check("slot_motor", motor, 4'b0001);
    wait_idle();

    // Same time but seconds != 0.
    seconds   = 6'd1;
    sec_pulse = 1'b1;
    step(1);
    sec_pulse = 1'b0;
    check("sec1_pend", pending, 0);
    step(2);
    check("sec1_busy", busy, 0);

    // Out-of-range slot time never matches.
    hours     = 5'd24;
    seconds   = 6'd0;
    sec_pulse = 1'b1;
    step(1);
    sec_pulse = 1'b0;
    hours     = 5'd9;
    check("bad_slot_pend", pending, 0);
    step(2);
    check("bad_slot_motor", motor, 0);

    // Manual request latency, then a request while busy.
    manual_req = 4'b0001;
    exp_q.push_back(4'b0001);
    step(1);
    manual_req = 4'h0;
    check("lat_pend", pending, 4'b0001);
    check("lat_motor0", motor, 0);
    step(1);
    check("lat_motor1", motor, 4'b0001);
    check("lat_pend_clr", pending, 0);
    step(1);
    manual_req = 4'b0010;
    exp_q.push_back(4'b0010);
    step(1);
    manual_req = 4'h0;
    check("busy_req_pend", pending, 4'b0010);
    check("busy_req_ovf", overflow, 0);
    wait_idle();
    check("busy_req_ovf_end", overflow, 0);

    // Duplicate request on an already pending channel.
    manual_req = 4'b0100;
    exp_q.push_back(4'b0100);
    step(1);
    manual_req = 4'h0;
    step(1);
    manual_req = 4'b0001;
    exp_q.push_back(4'b0001);
    step(1);
    check("dup_pend1", pending, 4'b0001);
    check("dup_ovf1", overflow, 0);
    step(1);
    manual_req = 4'h0;
    check("ovf_set", overflow, 4'b0001);
    check("ovf_pend", pending, 4'b0001);
    wait_idle();
    check("ovf_sticky", overflow, 4'b0001);

    // Late request on ch0 while ch1 pulses with ch2 waiting.
    manual_req = 4'b0110;
    exp_q.push_back(4'b0010);
    step(1);
    manual_req = 4'h0;
    step(1);
    check("prio_motor", motor, 4'b0010);
    manual_req = 4'b0001;
`ifdef DISPENSE_ROUND_ROBIN_EN
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0001);
`else
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0100);
`endif
    step(1);
    manual_req = 4'h0;
    check("prio_pend", pending, 4'b0101);
    wait_idle();

    // Reset in the middle of a pulse.
    manual_req = 4'b0001;
    exp_q.push_back(4'b0001);
    step(1);
    manual_req = 4'h0;
    step(1);
    manual_req = 4'b1000;
    step(1);
    manual_req = 4'h0;
    check("mid_pend", pending, 4'b1000);
    check("mid_motor", motor, 4'b0001);
    reset = 1'b0;
    exp_q.delete();
    step(1);
    check("mid_rst_motor", motor, 0);
    check("mid_rst_pending", pending, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_busy", busy, 0);
    reset = 1'b1;
    step(20);
    check("post_rst_motor", motor, 0);
    check("post_rst_pending", pending, 0);
    check("post_rst_busy", busy, 0);

    check("q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
